// File: rtl/counter_bcd_display.sv
// counter_bcd_display: samples a 16-bit binary value, converts it to five
// packed-BCD digits with a sequential double-dabble engine, and scans the
// digits onto a 5-digit active-low 7-segment display with leading-zero
// blanking. The captured carry flag lights the units decimal point.
module counter_bcd_display #(
    parameter int unsigned SCAN_DIV = 50000,
    parameter bit          LZ_BLANK = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] DIN,
    input  logic        CIN,
    output logic [19:0] BCD,
    output logic        VALID,
    output logic        BUSY,
    output logic [6:0]  SEG_N,
    output logic        DP_N,
    output logic [4:0]  AN_N
);

    localparam int unsigned DIN_W  = 16;
    localparam int unsigned BCD_W  = 20;
    localparam int unsigned SHR_W  = BCD_W + DIN_W;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned NDIG   = 5;

    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [DIN_W-1:0]   shadow;
    logic [DIN_W-1:0]   shadow_nxt;
    logic [SHR_W-1:0]   shreg;
    logic [SHR_W-1:0]   shreg_nxt;
    logic [SHR_W-1:0]   adj;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               carry_cap;
    logic               carry_nxt;
    logic [BCD_W-1:0]   bcd_nxt;
    logic               valid_nxt;
    logic               busy_nxt;

    logic [DIV_W-1:0]   div;
    logic [DIV_W-1:0]   div_nxt;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_nxt;
    logic [3:0]         digit;
    logic               blank;
    logic [6:0]         seg_nxt;
    logic [4:0]         an_nxt;
    logic               dp_nxt;

    // Active-low {g,f,e,d,c,b,a} pattern for one decimal digit.
    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Converter FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Converter next-state and datapath next values.
    always_comb begin
        state_nxt  = state;
        shadow_nxt = shadow;
        shreg_nxt  = shreg;
        cnt_nxt    = cnt;
        carry_nxt  = carry_cap;
        bcd_nxt    = BCD;
        valid_nxt  = 1'b0;
        adj        = shreg;

        case (state)
            S_IDLE: begin
                if (DIN != shadow) begin
                    shadow_nxt = DIN;
                    shreg_nxt  = {{BCD_W{1'b0}}, DIN};
                    carry_nxt  = CIN;
                    cnt_nxt    = '0;
                    state_nxt  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // Add 3 to each BCD nibble >= 5 so the shift carries decimally.
                for (int i = 0; i < int'(NDIG); i++) begin
                    if (adj[DIN_W + 4*i +: 4] >= 4'd5) begin
                        adj[DIN_W + 4*i +: 4] = adj[DIN_W + 4*i +: 4] + 4'd3;
                    end
                end
                shreg_nxt = {adj[SHR_W-2:0], 1'b0};
                cnt_nxt   = cnt + CNT_W'(1);
                if (cnt == CNT_W'(DIN_W - 1)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                bcd_nxt   = shreg[SHR_W-1:DIN_W];
                valid_nxt = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != S_IDLE);
    end

    // Converter datapath and status registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shadow    <= '0;
            shreg     <= '0;
            cnt       <= '0;
            carry_cap <= 1'b0;
            BCD       <= '0;
            VALID     <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            shadow    <= shadow_nxt;
            shreg     <= shreg_nxt;
            cnt       <= cnt_nxt;
            carry_cap <= carry_nxt;
            BCD       <= bcd_nxt;
            VALID     <= valid_nxt;
            BUSY      <= busy_nxt;
        end
    end

    // Scan divider, digit select, blanking and segment decode.
    always_comb begin
        div_nxt = div + DIV_W'(1);
        idx_nxt = idx;
        if (div == DIV_W'(SCAN_DIV - 1)) begin
            div_nxt = '0;
            idx_nxt = (idx == IDX_W'(NDIG - 1)) ? '0 : idx + IDX_W'(1);
        end

        digit = BCD[3:0];
        blank = 1'b0;
        case (idx_nxt)
            3'd1: begin
                digit = BCD[7:4];
                blank = (BCD[19:4] == 16'd0);
            end
            3'd2: begin
                digit = BCD[11:8];
                blank = (BCD[19:8] == 12'd0);
            end
            3'd3: begin
                digit = BCD[15:12];
                blank = (BCD[19:12] == 8'd0);
            end
            3'd4: begin
                digit = BCD[19:16];
                blank = (BCD[19:16] == 4'd0);
            end
            default: begin
                digit = BCD[3:0];
                blank = 1'b0;
            end
        endcase

        seg_nxt = (LZ_BLANK && blank) ? SEG_BLANK : decode(digit);
        an_nxt  = ~(5'd1 << idx_nxt);
        dp_nxt  = ~((idx_nxt == '0) && carry_cap);
    end

    // Registered scan state and display drive.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            div   <= '0;
            idx   <= '0;
            SEG_N <= SEG_ZERO;
            AN_N  <= 5'b11110;
            DP_N  <= 1'b1;
        end else begin
            div   <= div_nxt;
            idx   <= idx_nxt;
            SEG_N <= seg_nxt;
            AN_N  <= an_nxt;
            DP_N  <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_counter_bcd_display.sv
// tb_counter_bcd_display: directed and random conversions checked against an
// arithmetic decimal model, plus display scan, blanking and reset checks.
module tb_counter_bcd_display;

    localparam int unsigned SCAN = 4;

    logic        clk;
    logic        rst;
    logic [15:0] din;
    logic        cin;
    logic [19:0] bcd;
    logic        valid;
    logic        busy;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [4:0]  an_n;

    int tests;
    int fails;

    // Model state: last value the DUT is expected to have captured.
    logic [15:0] m_shadow;
    logic        m_carry;

    logic [6:0] seg_tab [10];
    int         pow10 [5];

    counter_bcd_display #(.SCAN_DIV(SCAN), .LZ_BLANK(1'b1)) dut (
        .CLK   (clk),
        .RST   (rst),
        .DIN   (din),
        .CIN   (cin),
        .BCD   (bcd),
        .VALID (valid),
        .BUSY  (busy),
        .SEG_N (seg_n),
        .DP_N  (dp_n),
        .AN_N  (an_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Decimal digits of v packed 4 bits each, computed arithmetically.
    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        r = '0;
        for (int k = 0; k < 5; k++) begin
            r[4*k +: 4] = 4'((v / pow10[k]) % 10);
        end
        return r;
    endfunction

    // Drive a value and check the whole conversion (latency, BUSY span, VALID).
    task automatic convert(input logic [15:0] v, input logic c);
        int edges;
        int busy_cnt;
        @(negedge clk);
        din = v;
        cin = c;
        if (v == m_shadow) begin
            repeat (3) begin
                @(posedge clk); #1;
                chk("no_conv_busy", 32'(busy), 32'd0);
                chk("no_conv_valid", 32'(valid), 32'd0);
            end
        end else begin
            @(posedge clk); #1;
            chk("busy_at_capture", 32'(busy), 32'd1);
            busy_cnt = 1;
            edges = 0;
            for (int n = 0; n < 40; n++) begin
                @(posedge clk); #1;
                edges++;
                if (valid) break;
                if (busy) busy_cnt++;
            end
            chk("valid_latency", 32'(edges), 32'd17);
            chk("busy_cycles", 32'(busy_cnt), 32'd17);
            chk("bcd_value", 32'(bcd), 32'(to_bcd(int'(v))));
            chk("busy_after_valid", 32'(busy), 32'd0);
            @(posedge clk); #1;
            chk("valid_one_cycle", 32'(valid), 32'd0);
            m_shadow = v;
            m_carry  = c;
        end
    endtask

    // Watch the scan for n cycles: rotation order, dwell time, digit, blank, DP.
    task automatic scan_check(input int n);
        int k;
        int prev_k;
        int run;
        bit seen;
        int v;
        logic [6:0] exp_seg;
        v = int'(m_shadow);
        prev_k = -1;
        run = 0;
        seen = 0;
        for (int t = 0; t < n; t++) begin
            @(posedge clk); #1;
            k = -1;
            for (int j = 0; j < 5; j++) begin
                if (an_n == ~(5'd1 << j)) k = j;
            end
            if (k < 0) begin
                chk("an_onehot", 32'(an_n), 32'h1E);
                continue;
            end
            if (k > 0 && v < pow10[k]) exp_seg = 7'h7F;
            else exp_seg = seg_tab[(v / pow10[k]) % 10];
            chk("seg_digit", 32'(seg_n), 32'(exp_seg));
            chk("dp", 32'(dp_n), (k == 0 && m_carry) ? 32'd0 : 32'd1);
            if (prev_k < 0) begin
                run = 1;
            end else if (k != prev_k) begin
                chk("an_next", 32'(k), 32'((prev_k + 1) % 5));
                if (seen) chk("an_period", 32'(run), 32'(SCAN));
                seen = 1;
                run = 1;
            end else begin
                run++;
            end
            prev_k = k;
        end
    endtask

    initial begin
        logic [15:0] rv;
        logic        rc;
        int          edges;
        tests = 0;
        fails = 0;
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        pow10 = '{1, 10, 100, 1000, 10000};
        m_shadow = 16'd0;
        m_carry  = 1'b0;
        rst = 1'b1;
        din = 16'd0;
        cin = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_bcd", 32'(bcd), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_an", 32'(an_n), 32'h1E);
        chk("rst_seg", 32'(seg_n), 32'h40);
        chk("rst_dp", 32'(dp_n), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(posedge clk); #1;
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_valid", 32'(valid), 32'd0);
            chk("idle_an_units", 32'(an_n), 32'h1E);
            chk("idle_seg_zero", 32'(seg_n), 32'h40);
        end
        scan_check(24);

        // Directed conversions.
        convert(16'd12345, 1'b0);
        scan_check(24);
        convert(16'hFFFF, 1'b1);
        scan_check(24);
        convert(16'd7, 1'b0);
        scan_check(44);

        // Change while busy: first result is the old value, then the new one.
        @(negedge clk);
        din = 16'd100;
        cin = 1'b0;
        @(posedge clk); #1;
        chk("chg_busy", 32'(busy), 32'd1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        din = 16'd200;
        cin = 1'b1;
        edges = 5;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            edges++;
            if (valid) break;
        end
        chk("chg_first_latency", 32'(edges), 32'd17);
        chk("chg_first_bcd", 32'(bcd), 32'h00100);
        @(posedge clk); #1;
        chk("chg_recapture_busy", 32'(busy), 32'd1);
        edges = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            edges++;
            if (valid) break;
        end
        chk("chg_second_latency", 32'(edges), 32'd17);
        chk("chg_second_bcd", 32'(bcd), 32'h00200);
        m_shadow = 16'd200;
        m_carry  = 1'b1;
        @(posedge clk); #1;
        scan_check(24);

        // Boundaries and repeats.
        convert(16'd200, 1'b0);
        convert(16'd10000, 1'b0);
        convert(16'd10, 1'b1);
        convert(16'd9, 1'b0);
        convert(16'd0, 1'b0);
        scan_check(24);

        // Random values.
        for (int r = 0; r < 12; r++) begin
            rv = 16'($urandom);
            if (r % 4 == 0) rv = 16'($urandom_range(0, 999));
            rc = 1'($urandom);
            convert(rv, rc);
            if (r % 3 == 0) scan_check(24);
        end

        // Reset in the middle of a conversion.
        convert(16'd4321, 1'b1);
        @(negedge clk);
        din = 16'd5555;
        @(posedge clk);
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_valid", 32'(valid), 32'd0);
        chk("mid_rst_bcd", 32'(bcd), 32'd0);
        chk("mid_rst_an", 32'(an_n), 32'h1E);
        chk("mid_rst_seg", 32'(seg_n), 32'h40);
        chk("mid_rst_dp", 32'(dp_n), 32'd1);
        din = 16'd0;
        cin = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_shadow = 16'd0;
        m_carry  = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_idle", 32'(busy), 32'd0);
        convert(16'd9, 1'b0);
        scan_check(24);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
